// File: rtl/jk_excite_driver_if.sv
// Target-word handshake between a producer and jk_excite_driver.
// The producer offers a target word and mode; the driver answers with ready.
`timescale 1ns/1ps
interface jk_excite_driver_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_target;
  logic             in_mode;

  modport master (
    output in_valid,
    output in_target,
    output in_mode,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_target,
    input  in_mode,
    output in_ready
  );
endinterface

// File: rtl/jk_excite_driver.sv
// Stimulus side of a JK register bank: resets and checks the bank, then for
// each accepted target word drives one cycle of J/K excitation computed from
// the bank's present q and reads the result back to report pass or fail.
`timescale 1ns/1ps
module jk_excite_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  jk_excite_driver_if.slave in_if,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             ff_rst,
  input  logic [WIDTH-1:0] q_fb,
  input  logic [WIDTH-1:0] qn_fb,
  output logic             done,
  output logic             err,
  output logic             init_err,
  output logic [7:0]       err_cnt,
  output logic [WIDTH-1:0] last_bad_q
);

  typedef enum logic [2:0] {
    INIT_RST,
    INIT_CHK,
    IDLE,
    DRIVE,
    CHECK
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] j_nxt;
  logic [WIDTH-1:0] k_nxt;
  logic             mismatch;

  assign in_if.in_ready = (state == IDLE);

  // Readback is good only if both rails agree with the latched target.
  assign mismatch = (q_fb != target) || (qn_fb != ~target);

  // Per-bit excitation taking the bank from its current q to the offered target.
  always_comb begin
    j_nxt = '0;
    k_nxt = '0;
    if (in_if.in_mode) begin
      j_nxt = in_if.in_target ^ q_fb;
      k_nxt = in_if.in_target ^ q_fb;
    end else begin
      j_nxt = in_if.in_target & ~q_fb;
      k_nxt = ~in_if.in_target & q_fb;
    end
  end

  // Control FSM with registered bank drive, status pulses and error bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT_RST;
      j          <= '0;
      k          <= '0;
      ff_rst     <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      init_err   <= 1'b0;
      err_cnt    <= 8'd0;
      last_bad_q <= '0;
      target     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        INIT_RST: begin
          ff_rst <= 1'b0;
          state  <= INIT_CHK;
        end
        INIT_CHK: begin
          if ((q_fb != '0) || (qn_fb != '1)) begin
            init_err <= 1'b1;
          end
          state <= IDLE;
        end
        IDLE: begin
          if (in_if.in_valid) begin
            target <= in_if.in_target;
            j      <= j_nxt;
            k      <= k_nxt;
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          j     <= '0;
          k     <= '0;
          state <= CHECK;
        end
        CHECK: begin
          done <= 1'b1;
          if (mismatch) begin
            err        <= 1'b1;
            last_bad_q <= q_fb;
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end
          state <= IDLE;
        end
        default: begin
          j      <= '0;
          k      <= '0;
          ff_rst <= 1'b1;
          state  <= INIT_RST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excite_driver.sv
// Directed bench for jk_excite_driver with a behavioural JK bank model that can
// have bits stuck at 0 or 1 on its feedback.
`timescale 1ns/1ps
module tb_jk_excite_driver;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] j, k, q_fb, qn_fb, last_bad_q;
  logic             ff_rst, done, err, init_err;
  logic [7:0]       err_cnt;
  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] stuck0 = '0;
  logic [WIDTH-1:0] stuck1 = '0;

  int n_cmp = 0;
  int n_bad = 0;

  jk_excite_driver_if #(.WIDTH(WIDTH)) in_if ();

  jk_excite_driver #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (in_if),
    .j          (j),
    .k          (k),
    .ff_rst     (ff_rst),
    .q_fb       (q_fb),
    .qn_fb      (qn_fb),
    .done       (done),
    .err        (err),
    .init_err   (init_err),
    .err_cnt    (err_cnt),
    .last_bad_q (last_bad_q)
  );

  always #5 clk = ~clk;

  // JK bank with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (ff_rst) begin
      bank_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j[i], k[i]})
          2'b10:   bank_q[i] <= 1'b1;
          2'b01:   bank_q[i] <= 1'b0;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: bank_q[i] <= bank_q[i];
        endcase
      end
    end
  end

  assign q_fb  = (bank_q & ~stuck0) | stuck1;
  assign qn_fb = ~q_fb;

  typedef struct {
    logic [7:0] tgt;
    logic       mode;
    logic [7:0] ej;
    logic [7:0] ek;
    logic [7:0] eq;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic release_reset(input logic exp_init_err);
    @(negedge clk);
    rst_n = 1'b1;
    check("rel_ff_rst_pre_e0", 32'(ff_rst), 32'd1);
    check("rel_ready_pre_e0", 32'(in_if.in_ready), 32'd0);
    @(posedge clk); #1;
    check("e0_ff_rst", 32'(ff_rst), 32'd0);
    check("e0_ready", 32'(in_if.in_ready), 32'd0);
    check("e0_jk", 32'({j, k}), 32'd0);
    @(posedge clk); #1;
    check("e1_ready", 32'(in_if.in_ready), 32'd1);
    check("e1_init_err", 32'(init_err), 32'(exp_init_err));
  endtask

  task automatic do_reset(input logic exp_init_err);
    @(negedge clk);
    in_if.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_ff_rst", 32'(ff_rst), 32'd1);
    check("rst_jk", 32'({j, k}), 32'd0);
    check("rst_ready", 32'(in_if.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_done_err_init", 32'({done, err, init_err}), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_last_bad_q", 32'(last_bad_q), 32'd0);
    release_reset(exp_init_err);
  endtask

  task automatic run_txn(input logic [7:0] tgt, input logic mode, input logic [7:0] exp_j,
                         input logic [7:0] exp_k, input logic exp_err, input string tag);
    int waitc;
    @(negedge clk);
    waitc = 0;
    while (!in_if.in_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, "_ready"}, 32'(in_if.in_ready), 32'd1);
    in_if.in_valid  = 1'b1;
    in_if.in_target = tgt;
    in_if.in_mode   = mode;
    @(posedge clk); #1;
    in_if.in_valid  = 1'b0;
    in_if.in_target = ~tgt;
    in_if.in_mode   = ~mode;
    check({tag, "_j"}, 32'(j), 32'(exp_j));
    check({tag, "_k"}, 32'(k), 32'(exp_k));
    check({tag, "_done_drive"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    check({tag, "_jk_check"}, 32'({j, k}), 32'd0);
    check({tag, "_done_check"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_ready_done"}, 32'(in_if.in_ready), 32'd1);
    @(posedge clk); #1;
    check({tag, "_done_fall"}, 32'(done), 32'd0);
  endtask

  // Watchdog so a stuck design still produces a summary line.
  initial begin
    #200000;
    n_bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Main directed sequence.
  initial begin
    int idx, dones, errs, acc_cyc[3];
    logic acc;

    vecs[0] = '{8'hA5, 1'b0, 8'hA5, 8'h00, 8'hA5};
    vecs[1] = '{8'h5A, 1'b1, 8'hFF, 8'hFF, 8'h5A};
    vecs[2] = '{8'h5A, 1'b0, 8'h00, 8'h00, 8'h5A};
    vecs[3] = '{8'h0F, 1'b0, 8'h05, 8'h50, 8'h0F};
    vecs[4] = '{8'hF0, 1'b1, 8'hFF, 8'hFF, 8'hF0};
    vecs[5] = '{8'h33, 1'b1, 8'hC3, 8'hC3, 8'h33};
    vecs[6] = '{8'h00, 1'b0, 8'h00, 8'h33, 8'h00};

    in_if.in_valid  = 1'b0;
    in_if.in_target = '0;
    in_if.in_mode   = 1'b0;
    rst_n = 1'b1;
    #1;
    do_reset(1'b0);

    for (int v = 0; v < 7; v++) begin
      run_txn(vecs[v].tgt, vecs[v].mode, vecs[v].ej, vecs[v].ek, 1'b0, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_q", v), 32'(q_fb), 32'(vecs[v].eq));
    end
    check("vec_err_cnt", 32'(err_cnt), 32'd0);

    stuck0 = 8'h08;
    run_txn(8'h08, 1'b0, 8'h08, 8'h00, 1'b1, "stk1");
    check("stk1_err_cnt", 32'(err_cnt), 32'd1);
    check("stk1_last_bad_q", 32'(last_bad_q), 32'h00);
    run_txn(8'hFF, 1'b0, 8'hFF, 8'h00, 1'b1, "stk2");
    check("stk2_err_cnt", 32'(err_cnt), 32'd2);
    check("stk2_last_bad_q", 32'(last_bad_q), 32'hF7);
    stuck0 = 8'h00;
    run_txn(8'h00, 1'b0, 8'h00, 8'hFF, 1'b0, "heal");
    check("heal_err_cnt", 32'(err_cnt), 32'd2);
    check("heal_last_bad_q", 32'(last_bad_q), 32'hF7);

    stuck0 = 8'h08;
    for (int i = 3; i <= 300; i++) begin
      run_txn(8'h08, 1'b0, 8'h08, 8'h00, 1'b1, "sat");
      if (i == 254) check("sat_cnt_254", 32'(err_cnt), 32'd254);
      if (i == 255) check("sat_cnt_255", 32'(err_cnt), 32'd255);
    end
    check("sat_cnt_300", 32'(err_cnt), 32'd255);
    check("sat_last_bad_q", 32'(last_bad_q), 32'h00);
    stuck0 = 8'h00;

    // Streaming with in_valid held high across three words.
    @(negedge clk);
    in_if.in_valid  = 1'b1;
    in_if.in_target = 8'h01;
    in_if.in_mode   = 1'b0;
    idx = 0; dones = 0; errs = 0;
    acc_cyc[0] = -1; acc_cyc[1] = -1; acc_cyc[2] = -1;
    for (int c = 0; c < 20 && !(idx == 3 && dones == 3); c++) begin
      acc = in_if.in_valid && in_if.in_ready;
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (err) errs++;
      end
      if (acc && idx < 3) begin
        acc_cyc[idx] = c;
        idx++;
        if (idx < 3) in_if.in_target = 8'(idx + 1);
        else         in_if.in_valid  = 1'b0;
      end
      @(negedge clk);
    end
    in_if.in_valid = 1'b0;
    check("strm_accepts", 32'(idx), 32'd3);
    check("strm_first_acc", 32'(acc_cyc[0]), 32'd0);
    check("strm_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    check("strm_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    check("strm_dones", 32'(dones), 32'd3);
    check("strm_errs", 32'(errs), 32'd0);
    check("strm_q", 32'(q_fb), 32'h03);

    // Reset pulsed during CHECK drops the transaction.
    @(negedge clk);
    in_if.in_valid  = 1'b1;
    in_if.in_target = 8'h55;
    in_if.in_mode   = 1'b0;
    @(posedge clk); #1;
    in_if.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_ff_rst", 32'(ff_rst), 32'd1);
    check("mid_jk", 32'({j, k}), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_ready", 32'(in_if.in_ready), 32'd0);
    check("mid_err_cnt", 32'(err_cnt), 32'd0);
    check("mid_last_bad_q", 32'(last_bad_q), 32'd0);
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("mid_no_done", 32'(dones), 32'd0);
    release_reset(1'b0);
    run_txn(8'h3C, 1'b1, 8'h3C, 8'h3C, 1'b0, "post");
    check("post_q", 32'(q_fb), 32'h3C);

    // Bank that fails its post-reset check.
    stuck1 = 8'h01;
    do_reset(1'b1);
    run_txn(8'h01, 1'b0, 8'h00, 8'h00, 1'b0, "ierr");
    check("ierr_sticky", 32'(init_err), 32'd1);
    stuck1 = 8'h00;
    do_reset(1'b0);
    run_txn(8'hC3, 1'b0, 8'hC3, 8'h00, 1'b0, "final");
    check("final_q", 32'(q_fb), 32'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
